multi_cycle_control: RTL and testbench

Multi-cycle control unit for the next CPU revision. It sequences one instruction over 2-5 cycles through IF/ID/EXE/MEM/WB. It drives the register-file write port (RegWre, RegOut, ALUM2Reg), PC, IR, ALU and data-memory strobes, and waits on a data-memory ready handshake. The register file remains a separate block that writes on negedge clk and ignores writes to register 0.

---
 rtl/multi_cycle_control_pkg.sv | 60 ++++++
 rtl/multi_cycle_control_decode.sv | 53 +++++
 rtl/multi_cycle_control.sv | 137 +++++++++++++
 tb/tb_multi_cycle_control.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_control_pkg.sv
// Shared opcode/funct/ALUOp/PCSrc codes, state encoding and decode bundle
// for the multi-cycle control unit and its decoder.
package multi_cycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_EXE_ALU  = 4'd2,
    S_EXE_BR   = 4'd3,
    S_EXE_ADDR = 4'd4,
    S_MEM      = 4'd5,
    S_WB_ALU   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_HALT     = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    C_ILL  = 3'd0,
    C_ALU  = 3'd1,
    C_BR   = 3'd2,
    C_MEM  = 3'd3,
    C_JMP  = 3'd4,
    C_HALT = 3'd5
  } cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [2:0] alu_op;
    logic       src_b;
    logic       ext;
    logic       reg_out;
    logic       store;
  } dec_t;

endpackage

// File: rtl/multi_cycle_control_decode.sv
// control_decode: opcode/funct -> instruction class and datapath fields.
// In: opcode_i, funct_i. Out: dec_o (class, ALUOp, ALUSrcB, ExtSel, RegOut, store).
module control_decode
  import multi_cycle_control_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode_i,
  input  logic [OPW-1:0] funct_i,
  output dec_t           dec_o
);

  always_comb begin
    dec_o = '{cls: C_ILL, alu_op: ALU_ADD, src_b: 1'b0,
              ext: 1'b0, reg_out: 1'b0, store: 1'b0};
    unique case (1'b1)
      opcode_i == OP_RTYPE: begin
        dec_o.cls = C_ALU;
        dec_o.reg_out = 1'b1;
        unique case (1'b1)
          funct_i == F_ADD: dec_o.alu_op = ALU_ADD;
          funct_i == F_SUB: dec_o.alu_op = ALU_SUB;
          funct_i == F_AND: dec_o.alu_op = ALU_AND;
          funct_i == F_OR:  dec_o.alu_op = ALU_OR;
          funct_i == F_SLT: dec_o.alu_op = ALU_SLT;
          default:          dec_o.cls = C_ILL;
        endcase
      end
      opcode_i == OP_ADDI: begin
        dec_o.cls = C_ALU;
        dec_o.src_b = 1'b1;
        dec_o.ext = 1'b1;
      end
      opcode_i == OP_ORI: begin
        dec_o.cls = C_ALU;
        dec_o.src_b = 1'b1;
        dec_o.alu_op = ALU_OR;
      end
      opcode_i == OP_LW: begin
        dec_o.cls = C_MEM;
      end
      opcode_i == OP_SW: begin
        dec_o.cls = C_MEM;
        dec_o.store = 1'b1;
      end
      opcode_i == OP_BEQ:  dec_o.cls = C_BR;
      opcode_i == OP_J:    dec_o.cls = C_JMP;
      opcode_i == OP_HALT: dec_o.cls = C_HALT;
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle control FSM: IF/ID/EXE/MEM/WB sequencing with memory wait.
// In: clk, rst_n, opcode, funct, zero, mem_ready. Out: datapath strobes, state.
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPW-1:0]    opcode,
  input  logic [OPW-1:0]    funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              PCWre,
  output logic              IRWre,
  output logic              RegWre,
  output logic              RegOut,
  output logic              ALUM2Reg,
  output logic              ALUSrcB,
  output logic              ExtSel,
  output logic [1:0]        PCSrc,
  output logic [ALUOPW-1:0] ALUOp,
  output logic              mRD,
  output logic              mWR,
  output logic              illegal,
  output logic              halted,
  output logic [3:0]        state
);

  state_e     state_q, state_d;
  dec_t       dec;
  logic [2:0] alu_op;

  control_decode #(.OPW(OPW)) u_dec (
    .opcode_i (opcode),
    .funct_i  (funct),
    .dec_o    (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  assign state = state_q;
  assign ALUOp = ALUOPW'(alu_op);

  // Outputs are gated by rst_n so strobes drop the moment reset asserts.
  always_comb begin
    state_d  = state_q;
    PCWre    = 1'b0;
    IRWre    = 1'b0;
    RegWre   = 1'b0;
    RegOut   = 1'b0;
    ALUM2Reg = 1'b0;
    ALUSrcB  = 1'b0;
    ExtSel   = 1'b0;
    PCSrc    = PC_NEXT;
    alu_op   = ALU_ADD;
    mRD      = 1'b0;
    mWR      = 1'b0;
    illegal  = 1'b0;
    halted   = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        S_IF: begin
          IRWre = 1'b1;
          state_d = S_ID;
        end
        S_ID: begin
          unique case (dec.cls)
            C_JMP: begin
              PCWre = 1'b1;
              PCSrc = PC_JMP;
              state_d = S_IF;
            end
            C_HALT: state_d = S_HALT;
            C_ALU:  state_d = S_EXE_ALU;
            C_BR:   state_d = S_EXE_BR;
            C_MEM:  state_d = S_EXE_ADDR;
            default: begin
              illegal = 1'b1;
              PCWre = 1'b1;
              state_d = S_IF;
            end
          endcase
        end
        S_EXE_ALU: begin
          ALUSrcB = dec.src_b;
          ExtSel = dec.ext;
          alu_op = dec.alu_op;
          state_d = S_WB_ALU;
        end
        S_WB_ALU: begin
          RegWre = 1'b1;
          RegOut = dec.reg_out;
          PCWre = 1'b1;
          state_d = S_IF;
        end
        S_EXE_BR: begin
          alu_op = ALU_SUB;
          ExtSel = 1'b1;
          PCWre = 1'b1;
          PCSrc = zero ? PC_BR : PC_NEXT;
          state_d = S_IF;
        end
        S_EXE_ADDR: begin
          ALUSrcB = 1'b1;
          ExtSel = 1'b1;
          state_d = S_MEM;
        end
        S_MEM: begin
          mWR = dec.store;
          mRD = !dec.store;
          if (mem_ready) begin
            if (dec.store) begin
              PCWre = 1'b1;
              state_d = S_IF;
            end else begin
              state_d = S_WB_MEM;
            end
          end
        end
        S_WB_MEM: begin
          RegWre = 1'b1;
          ALUM2Reg = 1'b1;
          PCWre = 1'b1;
          state_d = S_IF;
        end
        S_HALT: halted = 1'b1;
        default: state_d = S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: per-instruction cycle model and
// per-negedge comparison of every output against it.
module tb_multi_cycle_control;
  import multi_cycle_control_pkg::*;

  typedef struct packed {
    logic       pcwre;
    logic       irwre;
    logic       regwre;
    logic       regout;
    logic       alum2reg;
    logic       srcb;
    logic       ext;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       mrd;
    logic       mwr;
    logic       illegal;
    logic       halted;
    logic [3:0] st;
  } exp_t;

  typedef struct {
    exp_t e;
    logic mr;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       PCWre, IRWre, RegWre, RegOut, ALUM2Reg;
  logic       ALUSrcB, ExtSel, mRD, mWR, illegal, halted;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;
  logic [3:0] state;
  exp_t       got;

  multi_cycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .PCWre(PCWre),
    .IRWre(IRWre), .RegWre(RegWre), .RegOut(RegOut),
    .ALUM2Reg(ALUM2Reg), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
    .PCSrc(PCSrc), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR),
    .illegal(illegal), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  assign got = {PCWre, IRWre, RegWre, RegOut, ALUM2Reg, ALUSrcB,
                ExtSel, PCSrc, ALUOp, mRD, mWR, illegal, halted, state};

  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        expq[$];
  exp_t        cur;
  step_t       seq[$];
  int          p_req = 0;
  int          p_ack = 0;
  string       p_nm;
  logic [31:0] p_got, p_exp;

  always @(negedge clk or p_req) begin
    if (p_req != p_ack) begin
      p_ack = p_req;
      n_chk++;
      if (p_got !== p_exp) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h", p_nm, p_got, p_exp);
      end
    end else if (expq.size() != 0) begin
      cur = expq.pop_front();
      n_chk++;
      if (got !== cur) begin
        n_fail++;
        $display("FAIL cycle t=%0t op=%b: got %b expected %b",
                 $time, opcode, got, cur);
      end
    end
  end

  task automatic probe(input string nm, input logic [31:0] g,
                       input logic [31:0] x);
    p_nm = nm;
    p_got = g;
    p_exp = x;
    p_req++;
    #1;
  endtask

  function automatic exp_t blank(input state_e s);
    exp_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  function automatic void push(input exp_t e, input logic mr);
    step_t s;
    s.e = e;
    s.mr = mr;
    seq.push_back(s);
  endfunction

  // Kinds: 0 illegal, 1 R, 2 addi, 3 ori, 4 lw, 5 sw, 6 beq, 7 j, 8 halt
  function automatic void build(input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input int waits,
                                input int hold);
    int kind;
    logic [2:0] alu;
    exp_t e;
    alu = 3'b000;
    kind = 0;
    case (op)
      6'b000000: begin
        kind = 1;
        case (fn)
          6'b100000: alu = 3'b000;
          6'b100010: alu = 3'b001;
          6'b100100: alu = 3'b010;
          6'b100101: alu = 3'b011;
          6'b101010: alu = 3'b100;
          default:   kind = 0;
        endcase
      end
      6'b001000: kind = 2;
      6'b001101: begin kind = 3; alu = 3'b011; end
      6'b100011: kind = 4;
      6'b101011: kind = 5;
      6'b000100: kind = 6;
      6'b000010: kind = 7;
      6'b111111: kind = 8;
      default:   kind = 0;
    endcase
    seq.delete();
    e = blank(S_IF);
    e.irwre = 1'b1;
    push(e, 1'b1);
    e = blank(S_ID);
    if (kind == 7) begin
      e.pcwre = 1'b1;
      e.pcsrc = 2'b10;
      push(e, 1'b1);
    end else if (kind == 0) begin
      e.illegal = 1'b1;
      e.pcwre = 1'b1;
      push(e, 1'b1);
    end else if (kind == 8) begin
      push(e, 1'b1);
      e = blank(S_HALT);
      e.halted = 1'b1;
      for (int i = 0; i < hold; i++) push(e, 1'b1);
    end else if (kind <= 3) begin
      push(e, 1'b1);
      e = blank(S_EXE_ALU);
      e.aluop = alu;
      e.srcb = (kind != 1);
      e.ext = (kind == 2);
      push(e, 1'b1);
      e = blank(S_WB_ALU);
      e.regwre = 1'b1;
      e.regout = (kind == 1);
      e.pcwre = 1'b1;
      push(e, 1'b1);
    end else if (kind == 6) begin
      push(e, 1'b1);
      e = blank(S_EXE_BR);
      e.aluop = 3'b001;
      e.ext = 1'b1;
      e.pcwre = 1'b1;
      e.pcsrc = {1'b0, z};
      push(e, 1'b1);
    end else begin
      push(e, 1'b1);
      e = blank(S_EXE_ADDR);
      e.srcb = 1'b1;
      e.ext = 1'b1;
      push(e, 1'b1);
      for (int w = 0; w <= waits; w++) begin
        e = blank(S_MEM);
        e.mrd = (kind == 4);
        e.mwr = (kind == 5);
        e.pcwre = (kind == 5) && (w == waits);
        push(e, w == waits);
      end
      if (kind == 4) begin
        e = blank(S_WB_MEM);
        e.regwre = 1'b1;
        e.alum2reg = 1'b1;
        e.pcwre = 1'b1;
        push(e, 1'b1);
      end
    end
  endfunction

  // Entered and left at posedge+1; ncyc>0 truncates the instruction.
  task automatic run(input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input int waits, input int hold,
                     input int ncyc);
    int n;
    build(op, fn, z, waits, hold);
    opcode = op;
    funct = fn;
    zero = z;
    n = (ncyc > 0 && ncyc < seq.size()) ? ncyc : seq.size();
    for (int i = 0; i < n; i++) begin
      mem_ready = seq[i].mr;
      expq.push_back(seq[i].e);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    opcode = OP_J;
    funct = 6'd0;
    zero = 1'b1;
    mem_ready = 1'b1;
    #1;
    build(OP_RTYPE, F_ADD, 1'b0, 0, 0);
    probe("len_add", seq.size(), 4);
    build(OP_LW, 6'd0, 1'b0, 2, 0);
    probe("len_lw_w2", seq.size(), 7);
    probe("lw_wb_m2r", {31'd0, seq[6].e.alum2reg}, 1);
    build(OP_BEQ, 6'd0, 1'b1, 0, 0);
    probe("beq_taken_pcsrc", {30'd0, seq[2].e.pcsrc}, 1);
    build(OP_J, 6'd0, 1'b0, 0, 0);
    probe("j_id_pcsrc", {30'd0, seq[1].e.pcsrc}, 2);
    build(OP_ORI, 6'd0, 1'b0, 0, 0);
    probe("ori_exe", {27'd0, seq[2].e.aluop, seq[2].e.ext,
                      seq[2].e.srcb}, 32'b01101);
    build(OP_SW, 6'd0, 1'b0, 0, 0);
    probe("len_sw", seq.size(), 4);
    probe("reset_outs", {12'd0, got}, 0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(OP_RTYPE, F_ADD, 1'b0, 0, 0, 0);
    run(OP_LW, 6'd0, 1'b0, 2, 0, 0);
    run(OP_BEQ, 6'd0, 1'b1, 0, 0, 0);
    run(OP_BEQ, 6'd0, 1'b0, 0, 0, 0);
    run(OP_J, 6'd0, 1'b0, 0, 0, 0);
    run(6'b010101, 6'd0, 1'b0, 0, 0, 0);
    run(OP_RTYPE, 6'b000001, 1'b0, 0, 0, 0);
    run(OP_SW, 6'd0, 1'b1, 0, 0, 0);
    run(OP_ADDI, 6'd0, 1'b0, 0, 0, 0);
    run(OP_RTYPE, F_SUB, 1'b1, 0, 0, 0);
    run(OP_RTYPE, F_AND, 1'b0, 0, 0, 0);
    run(OP_RTYPE, F_OR, 1'b0, 0, 0, 0);
    run(OP_RTYPE, F_SLT, 1'b0, 0, 0, 0);
    run(OP_LW, 6'd0, 1'b0, 0, 0, 0);

    run(OP_SW, 6'd0, 1'b0, 5, 0, 4);
    probe("mwr_mid_mem", {31'd0, mWR}, 1);
    rst_n = 1'b0;
    #1;
    probe("async_rst_outs", {12'd0, got}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run(OP_ORI, 6'd0, 1'b0, 0, 0, 0);
    run(OP_HALT, 6'd0, 1'b0, 0, 20, 0);
    probe("still_halted", {31'd0, halted}, 1);
    rst_n = 1'b0;
    #1;
    probe("halt_rst", {31'd0, halted}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(OP_RTYPE, F_ADD, 1'b0, 0, 0, 0);

    for (int i = 0; i < 10 && expq.size() != 0; i++) @(negedge clk);
    #1;
    probe("queue_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
